id_ex_stage: RTL

- ID/EX pipeline register sitting directly upstream of the execute-stage ALU; it is the block that feeds the ALU its operands.
- Latches decoded operands and control fields each cycle.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts one bubble while stalling decode; accepts branch flush and downstream hold.

---
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use bubble insertion, branch flush and downstream hold.
module id_ex_stage #(
    parameter int DSIZE = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_op,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic [AW-1:0]    id_rd,
    input  logic [DSIZE-1:0] id_rdata1,
    input  logic [DSIZE-1:0] id_rdata2,
    input  logic [DSIZE-1:0] id_imm,
    input  logic             id_use_imm,
    input  logic             id_use_rs2,
    input  logic             id_wen,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_branch,
    input  logic [AW-1:0]    exm_rd,
    input  logic [AW-1:0]    mwb_rd,
    input  logic             exm_wen,
    input  logic             mwb_wen,
    input  logic [DSIZE-1:0] exm_result,
    input  logic [DSIZE-1:0] mwb_data,
    input  logic             flush,
    input  logic             hold,
    output logic             ex_valid,
    output logic             ex_wen,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_branch,
    output logic [2:0]       ex_op,
    output logic [AW-1:0]    ex_rd,
    output logic [DSIZE-1:0] ex_a,
    output logic [DSIZE-1:0] ex_b,
    output logic [DSIZE-1:0] ex_imm,
    output logic [DSIZE-1:0] ex_store_data,
    output logic             stall_id,
    output logic [15:0]      bubble_cnt
);

    logic [AW-1:0]    ex_rs1;
    logic [AW-1:0]    ex_rs2;
    logic [DSIZE-1:0] ex_rdata1;
    logic [DSIZE-1:0] ex_rdata2;
    logic             ex_use_imm;
    logic             load_use;
    logic [DSIZE-1:0] fwd1;
    logic [DSIZE-1:0] fwd2;

    always_comb begin
        load_use = 1'b0;
        if (ex_valid && ex_mem_read && id_valid && (ex_rd != '0))
            load_use = (ex_rd == id_rs1) || ((ex_rd == id_rs2) && id_use_rs2);
    end

    assign stall_id = (load_use | hold) & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_wen       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_op        <= '0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rdata1    <= '0;
            ex_rdata2    <= '0;
            ex_imm       <= '0;
            ex_use_imm   <= 1'b0;
            bubble_cnt   <= '0;
        end else if (hold && !flush) begin
            ex_valid <= ex_valid;
        end else if (flush || load_use) begin
            // Bubble: every field cleared so it carries no side effect downstream.
            ex_valid     <= 1'b0;
            ex_wen       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_op        <= '0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rdata1    <= '0;
            ex_rdata2    <= '0;
            ex_imm       <= '0;
            ex_use_imm   <= 1'b0;
            if (!flush && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end else begin
            ex_valid     <= id_valid;
            ex_wen       <= id_wen & id_valid;
            ex_mem_read  <= id_mem_read & id_valid;
            ex_mem_write <= id_mem_write & id_valid;
            ex_branch    <= id_branch & id_valid;
            ex_op        <= id_op;
            ex_rd        <= id_rd;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rdata1    <= id_rdata1;
            ex_rdata2    <= id_rdata2;
            ex_imm       <= id_imm;
            ex_use_imm   <= id_use_imm;
        end
    end

    // EX/MEM takes priority over MEM/WB; register 0 is never forwarded.
    always_comb begin
        if (ex_rs1 == '0)
            fwd1 = '0;
        else if (exm_wen && exm_rd == ex_rs1)
            fwd1 = exm_result;
        else if (mwb_wen && mwb_rd == ex_rs1)
            fwd1 = mwb_data;
        else
            fwd1 = ex_rdata1;
    end

    always_comb begin
        if (ex_rs2 == '0)
            fwd2 = '0;
        else if (exm_wen && exm_rd == ex_rs2)
            fwd2 = exm_result;
        else if (mwb_wen && mwb_rd == ex_rs2)
            fwd2 = mwb_data;
        else
            fwd2 = ex_rdata2;
    end

    assign ex_a          = fwd1;
    assign ex_store_data = fwd2;
    assign ex_b          = ex_use_imm ? ex_imm : fwd2;

endmodule
